// File: rtl/alu_mdu_seq.sv
// rtl/alu_mdu_seq.sv - handshaked execute-stage ALU with iterative RV32M/RV64M multiply/divide
// Define ALU_MDU_EN to compile in the multi-cycle multiplier/divider; otherwise M ops return 0xdeadbeef.
module alu_mdu_seq #(
  parameter  int XLEN = 32,
  localparam int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [4:0]      ALUControl,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] Result,
  output logic            Zero
);

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [XLEN-1:0] UNKNOWN_RES = XLEN'(32'hdeadbeef);

`ifdef ALU_MDU_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DONE = 2'd3} state_t;
`endif

  state_t          r_state, w_next, w_mdu_state;
  logic [XLEN-1:0] r_result, w_base, w_fast_res, w_mdu_res;
  logic [SHW-1:0]  w_shamt;
  logic            w_accept, w_busy, w_mdu_start, w_mdu_last;

  assign in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (r_state == S_DONE);
  assign w_busy    = (r_state != S_IDLE) && (r_state != S_DONE);
  assign Result    = r_result;
  assign Zero      = (r_result == '0);
  assign w_shamt   = B[SHW-1:0];

  always_comb begin
    w_base = UNKNOWN_RES;
    if (!ALUControl[4]) begin
      case (ALUControl[3:0])
        ALU_ADD:  w_base = A + B;
        ALU_SUB:  w_base = A - B;
        ALU_SLL:  w_base = A << w_shamt;
        ALU_SLT:  w_base = {{(XLEN-1){1'b0}}, $signed(A) < $signed(B)};
        ALU_SLTU: w_base = {{(XLEN-1){1'b0}}, A < B};
        ALU_XOR:  w_base = A ^ B;
        ALU_SRL:  w_base = A >> w_shamt;
        ALU_SRA:  w_base = $signed(A) >>> w_shamt;
        ALU_OR:   w_base = A | B;
        ALU_AND:  w_base = A & B;
        default:  w_base = UNKNOWN_RES;
      endcase
    end
  end

`ifdef ALU_MDU_EN
  logic [2:0]        w_f3;
  logic              w_is_m, w_is_div, w_a_signed, w_b_signed, w_a_neg, w_b_neg;
  logic              w_div0, w_ovf, w_special;
  logic [XLEN-1:0]   w_mag_a, w_mag_b, w_special_res, w_quo, w_rem;
  logic [XLEN:0]     w_sum, w_rs, w_diff;
  logic [2*XLEN-1:0] r_acc, w_acc_next, w_prod;
  logic [XLEN-1:0]   r_mcand;
  logic [SHW:0]      r_cnt;
  logic              r_sel, r_neg;

  assign w_f3       = ALUControl[2:0];
  assign w_is_m     = ALUControl[4] && !ALUControl[3];
  assign w_is_div   = w_f3[2];
  assign w_a_signed = w_is_div ? !w_f3[0] : (w_f3 != 3'd3);
  assign w_b_signed = w_is_div ? !w_f3[0] : !w_f3[1];
  assign w_a_neg    = w_a_signed && A[XLEN-1];
  assign w_b_neg    = w_b_signed && B[XLEN-1];
  assign w_mag_a    = w_a_neg ? -A : A;
  assign w_mag_b    = w_b_neg ? -B : B;
  assign w_div0     = (B == '0);
  assign w_ovf      = !w_f3[0] && (A == {1'b1, {(XLEN-1){1'b0}}}) && (B == '1);
  assign w_special  = w_is_m && w_is_div && (w_div0 || w_ovf);
  assign w_special_res = w_div0 ? (w_f3[1] ? A : '1) : (w_f3[1] ? '0 : A);

  assign w_mdu_start = w_is_m && !w_special;
  assign w_mdu_state = w_is_div ? S_DIV : S_MUL;
  assign w_fast_res  = w_special ? w_special_res : w_base;
  assign w_mdu_last  = (r_cnt == (SHW+1)'(1));

  // acc holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV
  assign w_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
  assign w_rs   = r_acc[2*XLEN-1:XLEN-1];
  assign w_diff = w_rs - {1'b0, r_mcand};

  always_comb begin
    w_acc_next = r_acc;
    if (r_state == S_MUL)
      w_acc_next = {w_sum, r_acc[XLEN-1:1]};
    else if (!w_diff[XLEN])
      w_acc_next = {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
    else
      w_acc_next = {w_rs[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
  end

  // Sign fix is folded into the last iteration so the result lands on the counter's 1->0 edge
  assign w_prod = r_neg ? -w_acc_next : w_acc_next;
  assign w_quo  = r_neg ? -w_acc_next[XLEN-1:0] : w_acc_next[XLEN-1:0];
  assign w_rem  = r_neg ? -w_acc_next[2*XLEN-1:XLEN] : w_acc_next[2*XLEN-1:XLEN];

  always_comb begin
    w_mdu_res = '0;
    if (r_state == S_MUL)
      w_mdu_res = r_sel ? w_prod[2*XLEN-1:XLEN] : w_prod[XLEN-1:0];
    else if (r_state == S_DIV)
      w_mdu_res = r_sel ? w_rem : w_quo;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc   <= '0;
      r_mcand <= '0;
      r_cnt   <= '0;
      r_sel   <= 1'b0;
      r_neg   <= 1'b0;
    end else if (w_accept && w_mdu_start) begin
      r_cnt   <= (SHW+1)'(XLEN);
      r_sel   <= w_is_div ? w_f3[1] : (w_f3 != 3'd0);
      r_neg   <= (w_is_div && w_f3[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
      r_mcand <= w_is_div ? w_mag_b : w_mag_a;
      r_acc   <= {{XLEN{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
    end else if (w_busy) begin
      r_acc   <= w_acc_next;
      r_cnt   <= r_cnt - (SHW+1)'(1);
    end
  end
`else
  assign w_mdu_start = 1'b0;
  assign w_mdu_last  = 1'b0;
  assign w_mdu_state = S_DONE;
  assign w_mdu_res   = '0;
  assign w_fast_res  = w_base;
`endif

  always_ff @(posedge clk) begin
    if (reset)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept)
          w_next = w_mdu_start ? w_mdu_state : S_DONE;
        else if ((r_state == S_DONE) && out_ready)
          w_next = S_IDLE;
      end
      default: begin
        if (w_mdu_last)
          w_next = S_DONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_result <= '0;
    else if (w_accept && !w_mdu_start)
      r_result <= w_fast_res;
    else if (w_busy && w_mdu_last)
      r_result <= w_mdu_res;
  end

endmodule

// File: tb/tb_alu_mdu_seq.sv
// tb/tb_alu_mdu_seq.sv - self-checking bench for alu_mdu_seq (vector table, directed corners, random vs model)
module tb_alu_mdu_seq;

  localparam logic [4:0] OP_ADD = 5'h00, OP_SLL = 5'h01, OP_SLT = 5'h02, OP_SLTU = 5'h03;
  localparam logic [4:0] OP_XOR = 5'h04, OP_SRL = 5'h05, OP_OR = 5'h06, OP_AND = 5'h07;
  localparam logic [4:0] OP_SUB = 5'h08, OP_SRA = 5'h0D;
  localparam logic [4:0] OP_MUL = 5'h10, OP_MULH = 5'h11, OP_MULHSU = 5'h12, OP_MULHU = 5'h13;
  localparam logic [4:0] OP_DIV = 5'h14, OP_DIVU = 5'h15, OP_REM = 5'h16, OP_REMU = 5'h17;
`ifdef ALU_MDU_EN
  localparam bit MDU = 1'b1;
`else
  localparam bit MDU = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, out_valid, out_ready, Zero;
  logic [31:0] A, B, Result;
  logic [4:0]  ALUControl;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_mdu_seq #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ALUControl(ALUControl), .out_valid(out_valid),
    .out_ready(out_ready), .Result(Result), .Zero(Zero)
  );

  typedef struct {
    string       name;
    logic [4:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mx(input logic [31:0] v);
    return MDU ? v : 32'hdeadbeef;
  endfunction

  function automatic int lx(input int l);
    return MDU ? l : 1;
  endfunction

  // Reference result from RISC-V semantics using wide products and native division
  function automatic logic [31:0] model(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, ua, sb, ub, p;
    sa = {{32{a[31]}}, a}; ua = {32'b0, a};
    sb = {{32{b[31]}}, b}; ub = {32'b0, b};
    if (!c[4]) begin
      case (c[3:0])
        4'h0: return a + b;
        4'h8: return a - b;
        4'h1: return a << b[4:0];
        4'h2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        4'h3: return (a < b) ? 32'd1 : 32'd0;
        4'h4: return a ^ b;
        4'h5: return a >> b[4:0];
        4'hD: return 32'($signed(a) >>> b[4:0]);
        4'h6: return a | b;
        4'h7: return a & b;
        default: return 32'hdeadbeef;
      endcase
    end
    if (!MDU || c[3]) return 32'hdeadbeef;
    case (c[2:0])
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hffffffff;
        if (a == 32'h80000000 && b == 32'hffffffff) return a;
        return 32'($signed(a) / $signed(b));
      end
      3'd5: return (b == 0) ? 32'hffffffff : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hffffffff) return 32'd0;
        return 32'($signed(a) % $signed(b));
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
    if (!MDU || !c[4] || c[3]) return 1;
    if (c[2] && (b == 0 || (!c[0] && a == 32'h80000000 && b == 32'hffffffff))) return 1;
    return 33;
  endfunction

  // Entered and left at a negedge; leaves out_ready=1 so the next call issues back-to-back
  task automatic run_op(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic zr, output int lat, output bit ir_ok);
    ALUControl = c; A = a; B = b; in_valid = 1'b1; out_ready = 1'b1;
    lat = 0; ir_ok = 1'b1;
    do begin
      @(negedge clk);
      lat++;
      in_valid = 1'b0; A = $urandom; B = $urandom; ALUControl = 5'($urandom);
      if (!out_valid && in_ready) ir_ok = 1'b0;
    end while (!out_valid && lat < 200);
    res = Result; zr = Zero;
  endtask

  task automatic check_op(input string nm, input logic [4:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int explat);
    logic [31:0] res; logic zr; int lat; bit ir_ok;
    run_op(c, a, b, res, zr, lat, ir_ok);
    chk({nm, "_res"}, 64'(res), 64'(exp));
    chk({nm, "_lat"}, 64'(lat), 64'(explat));
    chk({nm, "_zero"}, 64'(zr), 64'(exp == 0));
    chk({nm, "_inready_busy"}, 64'(ir_ok), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[$];
    logic [4:0]  ops[$];
    logic [31:0] res, hold, cr[$];
    logic        zr;
    int          lat;
    bit          ir_ok, never;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; ALUControl = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(Result), 64'd0);
    chk("rst_zero", 64'(Zero), 64'd1);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    vt.push_back('{"add", OP_ADD, 32'd7, 32'd5, 32'd12, 1});
    vt.push_back('{"sub_zero", OP_SUB, 32'd5, 32'd5, 32'd0, 1});
    vt.push_back('{"sub_neg", OP_SUB, 32'd0, 32'd1, 32'hffffffff, 1});
    vt.push_back('{"sra31", OP_SRA, 32'h80000000, 32'h3f, 32'hffffffff, 1});
    vt.push_back('{"sltu", OP_SLTU, 32'd1, 32'hffffffff, 32'd1, 1});
    vt.push_back('{"slt", OP_SLT, 32'd1, 32'hffffffff, 32'd0, 1});
    vt.push_back('{"sll", OP_SLL, 32'd1, 32'h21, 32'd2, 1});
    vt.push_back('{"srl", OP_SRL, 32'h80000000, 32'd4, 32'h08000000, 1});
    vt.push_back('{"xor", OP_XOR, 32'hf0f0, 32'hff00, 32'h0ff0, 1});
    vt.push_back('{"or", OP_OR, 32'hf0, 32'h0f, 32'hff, 1});
    vt.push_back('{"and", OP_AND, 32'hf0, 32'h0f, 32'h0, 1});
    vt.push_back('{"unk_base", 5'h09, 32'd1, 32'd2, 32'hdeadbeef, 1});
    vt.push_back('{"unk_m_bit3", 5'h18, 32'd1, 32'd2, 32'hdeadbeef, 1});
    vt.push_back('{"mulh", OP_MULH, 32'hfffffffe, 32'd3, mx(32'hffffffff), lx(33)});
    vt.push_back('{"mul", OP_MUL, 32'hfffffffe, 32'd3, mx(32'hfffffffa), lx(33)});
    vt.push_back('{"mulhu", OP_MULHU, 32'hffffffff, 32'hffffffff, mx(32'hfffffffe), lx(33)});
    vt.push_back('{"mulhsu", OP_MULHSU, 32'hffffffff, 32'hffffffff, mx(32'hffffffff), lx(33)});
    vt.push_back('{"mul_zero", OP_MUL, 32'd0, 32'd5, mx(32'd0), lx(33)});
    vt.push_back('{"div", OP_DIV, 32'hfffffff9, 32'd2, mx(32'hfffffffd), lx(33)});
    vt.push_back('{"rem", OP_REM, 32'hfffffff9, 32'd2, mx(32'hffffffff), lx(33)});
    vt.push_back('{"div_negb", OP_DIV, 32'd7, 32'hfffffffe, mx(32'hfffffffd), lx(33)});
    vt.push_back('{"rem_negb", OP_REM, 32'd7, 32'hfffffffe, mx(32'd1), lx(33)});
    vt.push_back('{"divu", OP_DIVU, 32'd100, 32'd7, mx(32'd14), lx(33)});
    vt.push_back('{"remu", OP_REMU, 32'd100, 32'd7, mx(32'd2), lx(33)});
    vt.push_back('{"divu_big", OP_DIVU, 32'h80000000, 32'hffffffff, mx(32'd0), lx(33)});
    vt.push_back('{"divu_by0", OP_DIVU, 32'd7, 32'd0, mx(32'hffffffff), 1});
    vt.push_back('{"div_by0", OP_DIV, 32'd7, 32'd0, mx(32'hffffffff), 1});
    vt.push_back('{"rem_by0", OP_REM, 32'hfffffff9, 32'd0, mx(32'hfffffff9), 1});
    vt.push_back('{"remu_by0", OP_REMU, 32'd9, 32'd0, mx(32'd9), 1});
    vt.push_back('{"div_ovf", OP_DIV, 32'h80000000, 32'hffffffff, mx(32'h80000000), 1});
    vt.push_back('{"rem_ovf", OP_REM, 32'h80000000, 32'hffffffff, mx(32'd0), 1});

    foreach (vt[i]) check_op(vt[i].name, vt[i].c, vt[i].a, vt[i].b, vt[i].exp, vt[i].lat);

    // Backpressure: completed result must hold while out_ready is low, then release and issue on one edge
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    ALUControl = OP_DIVU; A = 32'd100; B = 32'd7; in_valid = 1'b1; out_ready = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      in_valid = 1'b0;
    end while (!out_valid && lat < 200);
    chk("bp_lat", 64'(lat), 64'(lx(33)));
    chk("bp_res", 64'(Result), 64'(mx(32'd14)));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold_res", 64'(Result), 64'(mx(32'd14)));
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    end
    ALUControl = OP_ADD; A = 32'd3; B = 32'd4; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_add_valid", 64'(out_valid), 64'd1);
    chk("bp_add_res", 64'(Result), 64'd7);

    // Reset in the middle of an iterative op abandons it
    @(negedge clk);
    ALUControl = OP_MUL; A = 32'd6; B = 32'd7; in_valid = 1'b1; out_ready = 1'b1;
`ifdef ALU_MDU_EN
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_busy_in_ready", 64'(in_ready), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_result", 64'(Result), 64'd0);
    never = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) never = 1'b0;
    end
    chk("mid_rst_no_result", 64'(never), 64'd1);
`else
    @(negedge clk);
    in_valid = 1'b0;
    chk("nomdu_mul_valid", 64'(out_valid), 64'd1);
    chk("nomdu_mul_res", 64'(Result), 64'hdeadbeef);
    @(negedge clk);
`endif

    // Randomized ops against the reference model, with operands biased toward corners
    ops = '{OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
            OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    cr = '{32'h0, 32'h1, 32'hffffffff, 32'h80000000, 32'h7fffffff};
    for (int n = 0; n < 60; n++) begin
      logic [4:0]  c;
      logic [31:0] a, b;
      c = ($urandom_range(0, 9) == 0) ? 5'($urandom) : ops[$urandom_range(0, ops.size() - 1)];
      a = ($urandom_range(0, 3) == 0) ? cr[$urandom_range(0, cr.size() - 1)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? cr[$urandom_range(0, cr.size() - 1)] : $urandom;
      if ($urandom_range(0, 4) == 0) b = b & 32'h1f;
      run_op(c, a, b, res, zr, lat, ir_ok);
      hold = model(c, a, b);
      chk($sformatf("rand%0d_c%0h_res", n, c), 64'(res), 64'(hold));
      chk($sformatf("rand%0d_c%0h_lat", n, c), 64'(lat), 64'(model_lat(c, a, b)));
      chk($sformatf("rand%0d_zero", n), 64'(zr), 64'(hold == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
